// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load extraction, link formation and a
// debug counter of register writes that actually commit.
module writeback_stage #(
    parameter int LINK_OFFSET = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 EX_MEM_RegWrite,
    input  logic                 EX_MEM_MemToReg,
    input  logic                 EX_MEM_JmpandLink,
    input  logic [4:0]           EX_MEM_DstReg,
    input  logic [31:0]          EX_MEM_ALUResult,
    input  logic [31:0]          EX_MEM_PC,
    input  logic [2:0]           EX_MEM_LoadType,
    input  logic [31:0]          MEM_ReadData,
    output logic [4:0]           WB_DstReg,
    output logic [31:0]          WB_Data,
    output logic                 RegWrite,
    output logic                 MEM_WB_JmpandLink,
    output logic                 LoadFault,
    output logic [CNT_WIDTH-1:0] RetireCount
);

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LBU = 3'b010;
    localparam logic [2:0] LOAD_LH  = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic        jal_q;
    logic [4:0]  dst_q;
    logic [31:0] alu_q;
    logic [31:0] pc_q;
    logic [2:0]  load_type_q;
    logic [31:0] read_data_q;

    logic [1:0]  offset;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;
    logic        load_bad;
    logic [31:0] link_value;

    // Flush beats Stall so a bubble can always be forced in.
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            jal_q        <= 1'b0;
            dst_q        <= '0;
            alu_q        <= '0;
            pc_q         <= '0;
            load_type_q  <= '0;
            read_data_q  <= '0;
        end else if (!Stall) begin
            reg_write_q  <= EX_MEM_RegWrite;
            mem_to_reg_q <= EX_MEM_MemToReg;
            jal_q        <= EX_MEM_JmpandLink;
            dst_q        <= EX_MEM_DstReg;
            alu_q        <= EX_MEM_ALUResult;
            pc_q         <= EX_MEM_PC;
            load_type_q  <= EX_MEM_LoadType;
            read_data_q  <= MEM_ReadData;
        end
    end

    // The instruction in WB is counted once, on the edge where it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            RetireCount <= '0;
        end else if (RegWrite && (!Stall || Flush)) begin
            RetireCount <= RetireCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Big-endian lanes: byte 0 is the most significant byte of the word.
    always_comb begin
        offset     = alu_q[1:0];
        byte_sel   = 8'h00;
        load_value = 32'h0000_0000;
        load_bad   = 1'b0;
        case (offset)
            2'd0:    byte_sel = read_data_q[31:24];
            2'd1:    byte_sel = read_data_q[23:16];
            2'd2:    byte_sel = read_data_q[15:8];
            default: byte_sel = read_data_q[7:0];
        endcase
        half_sel = offset[1] ? read_data_q[15:0] : read_data_q[31:16];
        case (load_type_q)
            LOAD_LW: begin
                load_value = read_data_q;
                load_bad   = (offset != 2'd0);
            end
            LOAD_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: load_value = {24'h000000, byte_sel};
            LOAD_LH: begin
                load_value = {{16{half_sel[15]}}, half_sel};
                load_bad   = offset[0];
            end
            LOAD_LHU: begin
                load_value = {16'h0000, half_sel};
                load_bad   = offset[0];
            end
            default:  load_bad = 1'b1;
        endcase
    end

    assign link_value        = pc_q + 32'(LINK_OFFSET);
    assign LoadFault         = mem_to_reg_q & ~jal_q & load_bad;
    assign WB_DstReg         = jal_q ? 5'd31 : dst_q;
    assign WB_Data           = jal_q ? link_value : (mem_to_reg_q ? load_value : alu_q);
    assign RegWrite          = reg_write_q & ~LoadFault & ((dst_q != 5'd0) | jal_q);
    assign MEM_WB_JmpandLink = jal_q & reg_write_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a field-level
// reference model of the MEM/WB register and its writeback rules.
module tb_writeback_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        jal;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [2:0]  lt;
        logic [31:0] rd;
    } fields_t;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        rw;
        logic        jl;
        logic        fault;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    fields_t     drv = '0;

    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        reg_write;
    logic        wb_jl;
    logic        load_fault;
    logic [31:0] retire_count;

    fields_t     cap = '0;
    logic [31:0] cnt = '0;
    logic [31:0] base;
    int          tests = 0;
    int          failures = 0;

    writeback_stage #(.LINK_OFFSET(8), .CNT_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .Stall             (stall),
        .Flush             (flush),
        .EX_MEM_RegWrite   (drv.rw),
        .EX_MEM_MemToReg   (drv.m2r),
        .EX_MEM_JmpandLink (drv.jal),
        .EX_MEM_DstReg     (drv.dst),
        .EX_MEM_ALUResult  (drv.alu),
        .EX_MEM_PC         (drv.pc),
        .EX_MEM_LoadType   (drv.lt),
        .MEM_ReadData      (drv.rd),
        .WB_DstReg         (wb_dst),
        .WB_Data           (wb_data),
        .RegWrite          (reg_write),
        .MEM_WB_JmpandLink (wb_jl),
        .LoadFault         (load_fault),
        .RetireCount       (retire_count)
    );

    always #5 clk = ~clk;

    // Writeback result computed with shifts and arithmetic on the captured fields.
    function automatic wb_t expect_wb(input fields_t f);
        wb_t         w;
        int          o;
        logic [31:0] byte_v;
        logic [31:0] half_v;
        logic [31:0] val;
        logic        bad;
        o      = int'(f.alu % 4);
        byte_v = (f.rd >> (8 * (3 - o))) & 32'h0000_00FF;
        half_v = (f.rd >> (16 * (1 - o / 2))) & 32'h0000_FFFF;
        val    = 32'h0;
        bad    = 1'b0;
        case (f.lt)
            3'd0: begin val = f.rd; bad = (o != 0); end
            3'd1: val = (byte_v >= 32'h80) ? (byte_v - 32'h100) : byte_v;
            3'd2: val = byte_v;
            3'd3: begin val = (half_v >= 32'h8000) ? (half_v - 32'h10000) : half_v; bad = (o % 2 == 1); end
            3'd4: begin val = half_v; bad = (o % 2 == 1); end
            default: bad = 1'b1;
        endcase
        w.fault = f.m2r && !f.jal && bad;
        w.jl    = f.jal && f.rw;
        w.dst   = f.jal ? 5'd31 : f.dst;
        w.data  = f.jal ? f.pc + 32'd8 : (f.m2r ? val : f.alu);
        w.rw    = f.rw && !w.fault && (f.dst != 5'd0 || f.jal);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        wb_t w;
        w = expect_wb(cap);
        check({tag, "_dst"},   32'(wb_dst),     32'(w.dst));
        if (!w.fault)
            check({tag, "_data"}, wb_data,       w.data);
        check({tag, "_rw"},    32'(reg_write),  32'(w.rw));
        check({tag, "_jl"},    32'(wb_jl),      32'(w.jl));
        check({tag, "_fault"}, 32'(load_fault), 32'(w.fault));
        check({tag, "_count"}, retire_count,    cnt);
    endtask

    // One clock edge: advance the model by the same priority rules, then compare.
    task automatic apply_stimulus(input string tag);
        wb_t w;
        @(posedge clk);
        w = expect_wb(cap);
        if (rst) begin
            cap = '0;
            cnt = '0;
        end else begin
            if (w.rw && (!stall || flush)) cnt = cnt + 32'd1;
            if (flush)       cap = '0;
            else if (!stall) cap = drv;
        end
        #1;
        check_output(tag);
    endtask

    task automatic set_load(input logic [2:0] lt, input logic [1:0] o);
        drv = '{rw: 1'b1, m2r: 1'b1, jal: 1'b0, dst: 5'd7, alu: {30'h400, o},
                pc: 32'h100, lt: lt, rd: 32'h80FF_7F01};
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus("reset0");
        apply_stimulus("reset1");
        check("reset_count", retire_count, 32'h0);
        check("reset_data", wb_data, 32'h0);
        rst = 1'b0;

        drv = '{rw: 1'b1, m2r: 1'b0, jal: 1'b0, dst: 5'd5, alu: 32'h1234_5678,
                pc: 32'h0, lt: 3'd0, rd: 32'h0};
        apply_stimulus("alu");
        check("alu_data", wb_data, 32'h1234_5678);
        check("alu_dst", 32'(wb_dst), 32'd5);
        check("alu_rw", 32'(reg_write), 32'd1);
        drv = '0;
        apply_stimulus("alu_next");
        check("alu_count", retire_count, 32'd1);

        set_load(3'd1, 2'd0); apply_stimulus("lb");  check("lb_const",  wb_data, 32'hFFFF_FF80);
        set_load(3'd2, 2'd1); apply_stimulus("lbu"); check("lbu_const", wb_data, 32'h0000_00FF);
        set_load(3'd3, 2'd2); apply_stimulus("lh");  check("lh_const",  wb_data, 32'h0000_7F01);
        set_load(3'd4, 2'd0); apply_stimulus("lhu"); check("lhu_const", wb_data, 32'h0000_80FF);
        set_load(3'd0, 2'd0); apply_stimulus("lw");  check("lw_const",  wb_data, 32'h80FF_7F01);

        drv = '{rw: 1'b1, m2r: 1'b0, jal: 1'b1, dst: 5'd0, alu: 32'h0,
                pc: 32'h0000_0040, lt: 3'd0, rd: 32'h0};
        apply_stimulus("jal");
        check("jal_dst", 32'(wb_dst), 32'd31);
        check("jal_data", wb_data, 32'h48);
        check("jal_link", 32'(wb_jl), 32'd1);

        drv = '{rw: 1'b1, m2r: 1'b0, jal: 1'b0, dst: 5'd0, alu: 32'hDEAD,
                pc: 32'h0, lt: 3'd0, rd: 32'h0};
        apply_stimulus("r0");
        check("r0_rw", 32'(reg_write), 32'd0);
        base = cnt;
        drv = '0;
        apply_stimulus("r0_next");
        check("r0_count", retire_count, base);

        set_load(3'd0, 2'd2); apply_stimulus("lw_mis");   check("lw_mis_fault",   32'(load_fault), 32'd1);
        set_load(3'd3, 2'd1); apply_stimulus("lh_mis");   check("lh_mis_fault",   32'(load_fault), 32'd1);
        set_load(3'd6, 2'd0); apply_stimulus("lt_rsv");   check("lt_rsv_fault",   32'(load_fault), 32'd1);
        check("lt_rsv_rw", 32'(reg_write), 32'd0);

        drv = '{rw: 1'b1, m2r: 1'b0, jal: 1'b0, dst: 5'd9, alu: 32'hCAFE_0009,
                pc: 32'h0, lt: 3'd0, rd: 32'h0};
        apply_stimulus("stall_load");
        base = cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv = fields_t'({$urandom, $urandom, $urandom, $urandom});
            apply_stimulus("stall_hold");
            check("stall_frozen", wb_data, 32'hCAFE_0009);
            check("stall_count_hold", retire_count, base);
        end
        stall = 1'b0;
        drv = '0;
        apply_stimulus("stall_release");
        check("stall_count_once", retire_count, base + 32'd1);

        drv = '{rw: 1'b1, m2r: 1'b0, jal: 1'b0, dst: 5'd3, alu: 32'h33,
                pc: 32'h0, lt: 3'd0, rd: 32'h0};
        apply_stimulus("sf_load");
        base = cnt;
        stall = 1'b1;
        flush = 1'b1;
        apply_stimulus("stall_flush");
        check("sf_rw", 32'(reg_write), 32'd0);
        check("sf_count", retire_count, base + 32'd1);
        stall = 1'b0;
        flush = 1'b0;

        apply_stimulus("mid_load");
        rst = 1'b1;
        apply_stimulus("mid_reset");
        check("mid_reset_count", retire_count, 32'd0);
        check("mid_reset_rw", 32'(reg_write), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            drv     = fields_t'({$urandom, $urandom, $urandom, $urandom});
            drv.lt  = 3'($urandom_range(0, 7));
            drv.jal = ($urandom_range(0, 5) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 9) == 0) && expect_wb(cap).rw;
            apply_stimulus("rand");
        end
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
MEM/WB pipeline register plus writeback selection. It captures the memory-stage results and drives the write port of the register file (WB_DstReg, WB_Data, RegWrite, MEM_WB_JmpandLink). It performs load-data extraction and sign extension, forms the link value for jump-and-link, and honours stall and flush. It also keeps a retired-write counter for debug.

Parameters:
LINK_OFFSET, 8, byte offset added to the captured PC to form the JAL link value
CNT_WIDTH, 32, width of the retired-write counter

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
Stall  input  1  hold the MEM/WB register contents
Flush  input  1  load a bubble into the MEM/WB register
EX_MEM_RegWrite  input  1  instruction writes a register
EX_MEM_MemToReg  input  1  write data comes from memory, not the ALU
EX_MEM_JmpandLink  input  1  instruction is JAL/JALR-to-r31
EX_MEM_DstReg  input  5  destination register
EX_MEM_ALUResult  input  32  ALU result; also the load address
EX_MEM_PC  input  32  PC of the instruction
EX_MEM_LoadType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 reserved
MEM_ReadData  input  32  aligned word read from data memory
WB_DstReg  output  5  register-file write address
WB_Data  output  32  register-file write data
RegWrite  output  1  register-file write enable
MEM_WB_JmpandLink  output  1  link write to r31
LoadFault  output  1  misaligned or reserved-type load in WB this cycle
RetireCount  output  CNT_WIDTH  number of committed register writes

Behaviour:
- Register update, evaluated each posedge clk in this priority order:
  - rst: clear all MEM/WB fields to 0 and RetireCount to 0.
  - else Flush: load a bubble (all fields 0). Flush overrides Stall.
  - else Stall: hold all fields.
  - else capture all EX_MEM_* inputs and MEM_ReadData.
- Outputs are combinational from the registered fields only; there is no input-to-output combinational path.
  - Latency: inputs captured at edge N are visible from edge N until the next capture.
- After reset, all outputs are 0.
- Link writes:
  - When the captured JmpandLink=1, WB_DstReg=31 and WB_Data=PC+LINK_OFFSET (mod 2^32).
  - MEM_WB_JmpandLink follows the captured flag gated by the captured RegWrite.
- Non-link writes:
  - WB_DstReg is the captured DstReg.
  - WB_Data is the extracted load value when MemToReg=1, otherwise ALUResult.
- Load extraction is big-endian. The byte offset is o = ALUResult[1:0], and byte o occupies bits [31-8o : 24-8o].
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH/LHU select the half at o[1]: o=0 gives bits 31:16, o=2 gives bits 15:0. LH sign-extends; LHU zero-extends.
  - LW passes the whole word.
- LoadFault=1 when MemToReg=1 and any of the following holds:
  - LW with o!=0
  - LH/LHU with o[0]=1
  - a reserved LoadType
- RegWrite = captured RegWrite AND NOT LoadFault AND (DstReg!=0 OR JmpandLink).
  - A write to r0 is suppressed.
  - A faulting load never writes.
- JmpandLink takes precedence over MemToReg; LoadFault is 0 for link instructions.
- RetireCount increments by 1 at a posedge when RegWrite=1 and Stall=0, or when Flush=1 (the instruction leaves WB either way).
  - It wraps from all-ones to 0.
  - A held (stalled) instruction is counted once, on the edge where it leaves WB.
  - rst clears the counter, overriding any increment.
- Reset asserted mid-stream discards the in-flight instruction: no write, no count.

Test Plan:
- Reset, then ALU op RegWrite=1, DstReg=5, ALUResult=0x1234_5678, MemToReg=0 -> next cycle WB_DstReg=5, WB_Data=0x12345678, RegWrite=1; RetireCount=1 one edge later.
- Loads with MEM_ReadData=0x80FF_7F01:
  - LB o=0 -> 0xFFFFFF80
  - LBU o=1 -> 0x000000FF
  - LH o=2 -> 0x00007F01
  - LHU o=0 -> 0x000080FF
  - LW o=0 -> 0x80FF7F01
- JAL with PC=0x0000_0040, DstReg=0, RegWrite=1 -> WB_DstReg=31, WB_Data=0x48, MEM_WB_JmpandLink=1, RegWrite=1.
- ALU write to DstReg=0 -> RegWrite=0, no count increment.
- Faulting loads: LW o=2, LH o=1, and LoadType=110 -> LoadFault=1, RegWrite=0.
- Stall and flush:
  - Stall for 3 cycles while the inputs change -> outputs frozen, count incremented once only.
  - Stall=1 and Flush=1 together -> bubble loaded, RegWrite=0 next cycle.
  - rst asserted mid-stream -> all outputs and RetireCount=0 after that edge.
